p_accum_reg_c2x2_16bits: RTL and testbench

P_ACCUM_REG_C2X2_16BITS -- requirements
Module: p_accum_reg_c2x2_16bits

---
 rtl/p_accum_reg_c2x2_16bits.sv | 138 +++++++++++++
 tb/tb_p_accum_reg_c2x2_16bits.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/p_accum_reg_c2x2_16bits.sv
// p_accum_reg_c2x2_16bits
// Windowed P-register accumulator behind a 32-bit ALU. A start pulse opens a
// window of acc_len samples. Each valid ALU sum S becomes the new running
// value W_fb, which is fed back to the ALU. The last sample of the window is
// published on P with a one-cycle P_valid strobe, together with the
// per-lane sticky carry flags on OVF.
// Operand modes: 16x16 (a single 32-bit lane) or SIMD (two 16-bit lanes).
// Optional build macro PREG_SATURATE_EN: unsigned per-lane saturation. Once a
// lane's carry has been seen, that lane is forced to all-ones for the rest of
// the window.
// Handshake: in_valid qualifies S and result_SIMD_carry_out only in ACCUM.
// There is no back-pressure. P_valid pulses for exactly one cycle, and P/OVF
// hold their values until the next result or a reset.
module p_accum_reg_c2x2_16bits #(
    parameter int ACC_LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ACC_LEN_W-1:0] acc_len,
    input  logic                 USE_SIMD,
    input  logic                 in_valid,
    input  logic [31:0]          S,
    input  logic [1:0]           result_SIMD_carry_out,
    output logic [31:0]          W_fb,
    output logic                 busy,
    output logic [31:0]          P,
    output logic                 P_valid,
    output logic [1:0]           OVF,
    output logic [1:0]           o_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_w_fb;
    logic [31:0]            r_p;
    logic                   r_p_valid;
    logic [1:0]             r_ovf;
    logic [1:0]             r_sticky;
    logic [ACC_LEN_W-1:0]   r_count;
    logic [ACC_LEN_W-1:0]   r_len;
    logic                   r_simd;

    logic [1:0]             w_carry_mask;
    logic [1:0]             w_sticky_next;
    logic [ACC_LEN_W:0]     w_count_inc;
    logic                   w_last;
    logic [ACC_LEN_W-1:0]   w_count_next;
    logic [ACC_LEN_W-1:0]   w_len_start;
    logic [31:0]            w_acc_next;

    // In 16x16 mode the lane-0 carry is internal to the 32-bit add, so only bit 1 counts.
    always_comb begin
        w_carry_mask  = r_simd ? 2'b11 : 2'b10;
        w_sticky_next = r_sticky | (result_SIMD_carry_out & w_carry_mask);
        // The match is done one bit wider so that count+1 cannot alias a small length.
        w_count_inc   = {1'b0, r_count} + {{ACC_LEN_W{1'b0}}, 1'b1};
        w_last        = (w_count_inc == {1'b0, r_len});
        w_count_next  = (&r_count) ? r_count : w_count_inc[ACC_LEN_W-1:0];
        w_len_start   = (acc_len == '0) ? {{(ACC_LEN_W-1){1'b0}}, 1'b1} : acc_len;
    end

    // Next accumulator value. The sticky flag already covers the capture cycle,
    // so a saturated lane stays pinned for the rest of the window.
    always_comb begin
        w_acc_next = S;
`ifdef PREG_SATURATE_EN
        if (r_simd) begin
            w_acc_next[15:0]  = w_sticky_next[0] ? 16'hFFFF : S[15:0];
            w_acc_next[31:16] = w_sticky_next[1] ? 16'hFFFF : S[31:16];
        end else begin
            w_acc_next = w_sticky_next[1] ? 32'hFFFF_FFFF : S;
        end
`endif
    end

    // Window control FSM and all of its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_w_fb    <= '0;
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_ovf     <= '0;
            r_sticky  <= '0;
            r_count   <= '0;
            r_len     <= '0;
            r_simd    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_ACCUM;
                        r_w_fb   <= '0;
                        r_count  <= '0;
                        r_sticky <= '0;
                        r_len    <= w_len_start;
                        r_simd   <= USE_SIMD;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_w_fb   <= w_acc_next;
                        r_count  <= w_count_next;
                        r_sticky <= w_sticky_next;
                        if (w_last) begin
                            r_p       <= w_acc_next;
                            r_ovf     <= w_sticky_next;
                            r_p_valid <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_p_valid <= 1'b0;
                    r_w_fb    <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign W_fb        = r_w_fb;
    assign P           = r_p;
    assign P_valid     = r_p_valid;
    assign OVF         = r_ovf;
    assign busy        = (r_state != ST_IDLE);
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_p_accum_reg_c2x2_16bits.sv
// Directed bench for p_accum_reg_c2x2_16bits. Each window pushes its expected
// {OVF, P} onto a queue when it is started, and the entry is popped when the
// DUT strobes P_valid.
module tb_p_accum_reg_c2x2_16bits;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  acc_len;
    logic        USE_SIMD;
    logic        in_valid;
    logic [31:0] S;
    logic [1:0]  result_SIMD_carry_out;
    logic [31:0] W_fb;
    logic        busy;
    logic [31:0] P;
    logic        P_valid;
    logic [1:0]  OVF;
    logic [1:0]  o_state_dbg;

    logic [33:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pv_seen  = 0;
    int          pv_before;

    p_accum_reg_c2x2_16bits #(.ACC_LEN_W(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .acc_len               (acc_len),
        .USE_SIMD              (USE_SIMD),
        .in_valid              (in_valid),
        .S                     (S),
        .result_SIMD_carry_out (result_SIMD_carry_out),
        .W_fb                  (W_fb),
        .busy                  (busy),
        .P                     (P),
        .P_valid               (P_valid),
        .OVF                   (OVF),
        .o_state_dbg           (o_state_dbg)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every P_valid strobe, so that missing or extra strobes are visible.
    always @(posedge clk) if (P_valid === 1'b1) pv_seen <= pv_seen + 1;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, and outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input logic simd);
        start = 1'b1; acc_len = len; USE_SIMD = simd;
        tick();
        start = 1'b0; acc_len = $urandom_range(0, 255); USE_SIMD = $urandom_range(0, 1);
    endtask

    task automatic send(input logic [31:0] s, input logic [1:0] c);
        in_valid = 1'b1; S = s; result_SIMD_carry_out = c;
        tick();
        in_valid = 1'b0; S = $urandom; result_SIMD_carry_out = $urandom_range(0, 3);
    endtask

    task automatic gap();
        tick();
    endtask

    // Called right after the final sample's edge: the strobe must be up now, and down one cycle later.
    task automatic check_result(input string tag);
        logic [33:0] e;
        check({tag, " P_valid"}, {33'd0, P_valid}, 34'd1);
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 34'd0, 34'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " P"},   {2'b00, P},   {2'b00, e[31:0]});
            check({tag, " OVF"}, {32'd0, OVF}, {32'd0, e[33:32]});
        end
        in_valid = 1'b1; S = 32'hDEAD_BEEF; // must be ignored in DONE
        tick();
        in_valid = 1'b0;
        check({tag, " P_valid drop"}, {33'd0, P_valid}, 34'd0);
        check({tag, " W_fb clear"},   {2'b00, W_fb},    34'd0);
        check({tag, " busy idle"},    {33'd0, busy},    34'd0);
        check({tag, " P hold"},       {2'b00, P},       {2'b00, e[31:0]});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; acc_len = '0; USE_SIMD = 1'b0;
        in_valid = 1'b0; S = '0; result_SIMD_carry_out = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset W_fb",    {2'b00, W_fb},    34'd0);
        check("reset P",       {2'b00, P},       34'd0);
        check("reset P_valid", {33'd0, P_valid}, 34'd0);
        check("reset OVF",     {32'd0, OVF},     34'd0);
        check("reset busy",    {33'd0, busy},    34'd0);

        // 16x16 mode, three samples with no carries.
        exp_q.push_back({2'b00, 32'h0000_0060});
        do_start(8'd3, 1'b0);
        check("t1 busy", {33'd0, busy}, 34'd1);
        send(32'h10, 2'b00);
        check("t1 W_fb", {2'b00, W_fb}, {2'b00, 32'h10});
        send(32'h30, 2'b00);
        check("t1 no early P_valid", {33'd0, P_valid}, 34'd0);
        send(32'h60, 2'b00);
        check_result("t1");

        // SIMD mode, lane-0 carry on the second sample.
`ifdef PREG_SATURATE_EN
        exp_q.push_back({2'b01, 32'h0002_FFFF});
`else
        exp_q.push_back({2'b01, 32'h0002_0005});
`endif
        do_start(8'd2, 1'b1);
        send(32'h0001_FFFF, 2'b00);
        send(32'h0002_0005, 2'b01);
        check_result("t2");

        // acc_len = 0 is treated as a single sample.
        exp_q.push_back({2'b00, 32'hABCD_1234});
        do_start(8'd0, 1'b0);
        send(32'hABCD_1234, 2'b00);
        check_result("t3");

        // 16x16 mode: the lane-0 carry is ignored, and the lane-1 carry is sticky.
`ifdef PREG_SATURATE_EN
        exp_q.push_back({2'b10, 32'hFFFF_FFFF});
`else
        exp_q.push_back({2'b10, 32'h0000_0001});
`endif
        do_start(8'd2, 1'b0);
        send(32'h1234_0000, 2'b11);
        send(32'h0000_0001, 2'b00);
        check_result("t4");

        // SIMD mode: lane-1 carry only.
`ifdef PREG_SATURATE_EN
        exp_q.push_back({2'b10, 32'hFFFF_6666});
`else
        exp_q.push_back({2'b10, 32'h5555_6666});
`endif
        do_start(8'd1, 1'b1);
        send(32'h5555_6666, 2'b10);
        check_result("t5");

        // A second start and a USE_SIMD toggle mid-window, with gaps in in_valid.
        exp_q.push_back({2'b00, 32'h0000_0444});
        do_start(8'd4, 1'b0);
        send(32'h111, 2'b01);
        gap();
        start = 1'b1; acc_len = 8'd1; USE_SIMD = 1'b1;
        tick();
        start = 1'b0;
        send(32'h222, 2'b01);
        gap(); gap();
        send(32'h333, 2'b00);
        check("t6 still busy",  {33'd0, busy},    34'd1);
        check("t6 no P_valid",  {33'd0, P_valid}, 34'd0);
        send(32'h444, 2'b01);
        check_result("t6");

        // Reset after 2 of 4 samples aborts the window without a strobe.
        pv_before = pv_seen;
        do_start(8'd4, 1'b0);
        send(32'h7, 2'b10);
        send(32'h8, 2'b00);
        reset = 1'b1; in_valid = 1'b1; start = 1'b1; S = 32'h9;
        tick();
        reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        tick(); tick();
        check("t7 P",        {2'b00, P},       34'd0);
        check("t7 OVF",      {32'd0, OVF},     34'd0);
        check("t7 W_fb",     {2'b00, W_fb},    34'd0);
        check("t7 busy",     {33'd0, busy},    34'd0);
        check("t7 no strobe", pv_seen - pv_before, 34'd0);

        exp_q.push_back({2'b00, 32'h0000_00AA});
        do_start(8'd1, 1'b0);
        send(32'hAA, 2'b00);
        check_result("t8");

        check("strobe count", pv_seen, 34'd7);
        check("queue empty", exp_q.size(), 34'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
